func_call_engine: RTL and testbench
===================================

# func_call_engine

Multi-channel, pipelined function-evaluation engine for WIDTH-bit arguments. NCH requesters each issue a call (argument plus opcode) over a valid/ready handshake. A round-robin arbiter admits one call per cycle into a two-stage evaluation pipeline. Results are returned in admission order through a DEPTH-entry output FIFO, tagged with the calling channel. It sits between caller modules and a shared consumer, replacing per-instance single-argument combinational function calls with a shared, flow-controlled unit.

## Interface
- WIDTH, 8, argument/result width in bits (≥2)
- NCH, 4, number of request channels (≥2)
- DEPTH, 4, output FIFO entries (≥2, power of two)
- CHW, $clog2(NCH), derived channel-tag width; not to be overridden
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  NCH  per-channel call request
- req_ready  output  NCH  per-channel accept; at most one bit high per cycle
- req_arg  input  NCH*WIDTH  channel i argument at [i*WIDTH +: WIDTH]
- req_op  input  NCH*2  channel i opcode at [i*2 +: 2]
- rsp_valid  output  1  FIFO head valid
- rsp_ready  input  1  consumer accepts head
- rsp_data  output  WIDTH  result at FIFO head
- rsp_ch  output  CHW  originating channel of head

## Operation
- Opcodes:
  - 00 identity: result = arg.
  - 01 invert: result = ~arg.
  - 10 increment: result = arg+1 mod 2^WIDTH; all-ones wraps to 0.
  - 11 parity: result = {WIDTH-1 zeros, ^arg}.
- Credit: `credit_ok = (fifo_count + inflight) < DEPTH`.
  - inflight = number of valid pipeline stages (0..2).
  - Counts use the pre-edge values. A same-cycle pop does not create credit until the next cycle.
- Arbiter: combinational round-robin over req_valid, gated by credit_ok.
  - Search starts at `ptr`: the channel after the last granted one. Reset value of `ptr` is 0.
  - `req_ready[g]` is high only for the granted channel g, and only when credit_ok.
  - A call is accepted when `req_valid[g] && req_ready[g]`. On accept, `ptr` ← (g+1) mod NCH.
  - `ptr` is unchanged when nothing is accepted.
- Stage S1 registers arg, op and channel of the accepted call, plus a valid bit.
- Stage S2 registers the computed result, channel and valid bit.
- S2 valid pushes into the FIFO on the next edge. Credit guarantees that push never overflows.
- FIFO is first-word-fall-through:
  - rsp_valid = (count ≠ 0); rsp_data and rsp_ch reflect the head.
  - Pop occurs when `rsp_valid && rsp_ready`.
  - A push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Callers may change req_arg or req_op while not accepted. Only values sampled on the accept edge are used.
- Reset asserted mid-operation discards all in-flight and queued calls; no partial results are emitted after reset.

## Timing
- Reset values:
  - req_ready = 0 while reset_n low.
  - rsp_valid = 0, rsp_data = 0, rsp_ch = 0.
  - ptr = 0; FIFO pointers and count = 0; S1/S2 valid = 0.
- Latency: call accepted at edge T is in S1 after T, S2 after T+1, and in the FIFO after T+2.
  - rsp_valid is high in the cycle following edge T+2 when the FIFO was empty.
- Throughput: one call per cycle while the consumer keeps rsp_ready high and credit holds.
- With rsp_ready held low, at most DEPTH calls are accepted in total. req_ready stays low afterwards until a pop frees credit.
- req_ready depends combinationally on req_valid; rsp_* are registered or derived from the FIFO only.
- Reset deassertion: first grant is possible in the first cycle after reset_n rises.

## Test plan
- Single call: ch2 sends arg=0xFF, op=10 at T; rsp_ready=1 → rsp_valid high after edge T+2 with rsp_data=0x00, rsp_ch=2, then low.
- Round robin: all four channels valid continuously, op=00, arg=channel index, rsp_ready=1 → grant order 0,1,2,3,0,…; responses 0,1,2,3 on consecutive cycles.
- Backpressure: rsp_ready=0, all channels valid → exactly 4 accepts, req_ready then 0. Raising rsp_ready for one cycle → exactly one further accept, no loss or duplication.
- Opcodes on arg=0xA5 → op00 0xA5, op01 0x5A, op10 0xA6, op11 0x00. Repeat on arg=0x07 → op11 result 0x01.
- Reset mid-stream: 3 calls in flight plus 2 queued, reset_n pulsed low → rsp_valid=0, and after release the first response comes from a post-reset call only.
- Parameter sweep WIDTH=16, NCH=3, DEPTH=8: the random-traffic scoreboard matches expected results, tags and per-channel order for ≥10,000 calls.

Source files
------------

// File: rtl/func_call_engine.sv
// Shared function-evaluation engine: round-robin admission of per-channel calls,
// two-stage evaluation pipeline and a FWFT result FIFO tagged with the caller.
module func_call_engine #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int DEPTH = 4,
  localparam int CHW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       req_valid,
  output logic [NCH-1:0]       req_ready,
  input  logic [NCH*WIDTH-1:0] req_arg,
  input  logic [NCH*2-1:0]     req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic [CHW-1:0]       rsp_ch
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] arg_w [NCH];
  logic [1:0]       op_w  [NCH];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign arg_w[gi] = req_arg[gi*WIDTH +: WIDTH];
      assign op_w[gi]  = req_op[gi*2 +: 2];
    end
  endgenerate

  logic [CHW-1:0]   ptr_reg, ptr_next, gnt;
  logic             found, credit_ok, accept;
  logic [CW:0]      occupancy;
  logic             s1_valid_reg, s2_valid_reg;
  logic [WIDTH-1:0] s1_arg_reg, s2_data_reg, result_next;
  logic [1:0]       s1_op_reg;
  logic [CHW-1:0]   s1_ch_reg, s2_ch_reg;
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push, pop;
  logic [CHW+WIDTH-1:0] mem [DEPTH];

  // Occupancy counts everything admitted but not yet popped, so a push can never overflow.
  assign occupancy = (CW+1)'(count_reg) + (CW+1)'(s1_valid_reg) + (CW+1)'(s2_valid_reg);
  assign credit_ok = occupancy < (CW+1)'(DEPTH);

  always_comb begin
    found = 1'b0;
    gnt   = ptr_reg;
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = int'(ptr_reg) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = CHW'(idx);
      end
    end
  end

  assign accept    = found && credit_ok && reset_n;
  assign req_ready = accept ? (NCH'(1) << gnt) : '0;
  assign ptr_next  = (gnt == CHW'(NCH-1)) ? '0 : gnt + 1'b1;

  always_comb begin
    result_next = s1_arg_reg;
    case (s1_op_reg)
      2'b00: result_next = s1_arg_reg;
      2'b01: result_next = ~s1_arg_reg;
      2'b10: result_next = s1_arg_reg + 1'b1;
      2'b11: result_next = {{(WIDTH-1){1'b0}}, ^s1_arg_reg};
    endcase
  end

  assign push      = s2_valid_reg;
  assign rsp_valid = (count_reg != '0);
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_reg      <= '0;
      s1_valid_reg <= 1'b0;
      s1_arg_reg   <= '0;
      s1_op_reg    <= '0;
      s1_ch_reg    <= '0;
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
      s2_ch_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      if (accept) ptr_reg <= ptr_next;
      s1_valid_reg <= accept;
      s1_arg_reg   <= arg_w[gnt];
      s1_op_reg    <= op_w[gnt];
      s1_ch_reg    <= gnt;
      s2_valid_reg <= s1_valid_reg;
      s2_data_reg  <= result_next;
      s2_ch_reg    <= s1_ch_reg;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is left unreset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {s2_ch_reg, s2_data_reg};
  end

  assign rsp_data = rsp_valid ? mem[rd_ptr_reg][WIDTH-1:0] : '0;
  assign rsp_ch   = rsp_valid ? mem[rd_ptr_reg][CHW+WIDTH-1:WIDTH] : '0;

endmodule

// File: tb/tb_func_call_engine.sv
// Scoreboard bench: the monitor predicts grants from a round-robin/credit model and
// checks every popped response against a behavioural function model.
module tb_func_call_engine;
  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int CHW   = $clog2(NCH);

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NCH-1:0]       req_valid = '0;
  logic [NCH-1:0]       req_ready;
  logic [NCH*WIDTH-1:0] req_arg = '0;
  logic [NCH*2-1:0]     req_op = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [WIDTH-1:0]     rsp_data;
  logic [CHW-1:0]       rsp_ch;

  func_call_engine #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_arg(req_arg), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ch(rsp_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               ch;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   outstanding = 0;
  int   mptr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_f(input logic [WIDTH-1:0] a, input logic [1:0] op);
    int unsigned v;
    case (op)
      2'd0: v = int'(a);
      2'd1: v = (2**WIDTH - 1) - int'(a);
      2'd2: v = (int'(a) + 1) % (2**WIDTH);
      default: v = $countones(a) % 2;
    endcase
    return WIDTH'(v);
  endfunction

  // Monitor: inputs only change just after a rising edge, so the falling edge sees
  // exactly what the next rising edge will sample.
  always @(negedge clk) begin
    logic [NCH-1:0] exp_ready;
    exp_t e;
    int   g;
    if (!reset_n) begin
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_rsp_data", 64'(rsp_data), 64'd0);
      check("reset_rsp_ch", 64'(rsp_ch), 64'd0);
      check("reset_req_ready", 64'(req_ready), 64'd0);
      sb.delete();
      outstanding = 0;
      mptr = 0;
    end else begin
      exp_ready = '0;
      g = -1;
      if (outstanding < DEPTH) begin
        for (int k = 0; k < NCH; k++) begin
          if (g < 0 && req_valid[(mptr + k) % NCH]) g = (mptr + k) % NCH;
        end
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      if (rsp_valid && sb.size() == 0) check("rsp_valid_without_call", 64'(rsp_valid), 64'd0);
      if (g >= 0 && req_ready == exp_ready) begin
        e.data = ref_f(req_arg[g*WIDTH +: WIDTH], req_op[g*2 +: 2]);
        e.ch   = g;
        sb.push_back(e);
        $display("accept ch=%0d arg=%0h op=%0d", g, req_arg[g*WIDTH +: WIDTH], req_op[g*2 +: 2]);
        mptr = (g + 1) % NCH;
        outstanding++;
        n_acc++;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("pop_with_empty_scoreboard", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          $display("response ch=%0d data=%0h (expected ch=%0d data=%0h)", rsp_ch, rsp_data, e.ch, e.data);
          check("rsp_data", 64'(rsp_data), 64'(e.data));
          check("rsp_ch", 64'(rsp_ch), 64'(e.ch));
          outstanding--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] a, input logic [1:0] op);
    req_arg[ch*WIDTH +: WIDTH] = a;
    req_op[ch*2 +: 2] = op;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    int a0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Single call with wraparound increment, exact latency
    rsp_ready = 1'b1;
    set_ch(2, 8'hFF, 2'b10);
    req_valid = 4'b0100;
    @(negedge clk);
    check("single_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    @(negedge clk); check("lat_s1_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk); check("lat_s2_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk); check("lat_fifo_rsp_valid", 64'(rsp_valid), 64'd1);
    check("single_data", 64'(rsp_data), 64'h00);
    check("single_ch", 64'(rsp_ch), 64'd2);
    @(negedge clk); check("single_after_pop", 64'(rsp_valid), 64'd0);
    drain();

    // Opcodes on 0xA5, then parity of 0x07
    for (int c = 0; c < NCH; c++) set_ch(c, 8'hA5, 2'(c));
    req_valid = '1;
    repeat (NCH) tick();
    req_valid = '0;
    set_ch(1, 8'h07, 2'b11);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    drain();

    // Round robin at full throughput
    for (int c = 0; c < NCH; c++) set_ch(c, WIDTH'(c), 2'b00);
    a0 = n_acc;
    req_valid = '1;
    repeat (20) tick();
    check("rr_throughput", 64'(n_acc - a0), 64'd20);
    drain();

    // Backpressure: DEPTH accepts, then one more per freed slot
    rsp_ready = 1'b0;
    a0 = n_acc;
    req_valid = '1;
    repeat (10) tick();
    check("bp_accepts", 64'(n_acc - a0), 64'(DEPTH));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    repeat (6) tick();
    check("bp_one_more", 64'(n_acc - a0), 64'(DEPTH + 1));

    // Reset with calls both in flight and queued
    rsp_ready = 1'b1;
    repeat (2) tick();
    rsp_ready = 1'b0;
    tick();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_reset_idle", 64'(rsp_valid), 64'd0);
    end
    tick();
    set_ch(1, 8'h3C, 2'b00);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    drain();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      req_valid = NCH'($urandom);
      for (int c = 0; c < NCH; c++) set_ch(c, WIDTH'($urandom), 2'($urandom));
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
